// File: rtl/gth_bringup_pkg.sv
// Shared types and constants for the GTH link bring-up sequencer.
// The state encoding is also exported raw on the debug port.
package gth_bringup_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        WAIT_PWR    = 4'd1,
        ASSERT_RST  = 4'd2,
        WAIT_TXDONE = 4'd3,
        WAIT_CLK    = 4'd4,
        RELEASE     = 4'd5,
        UP          = 4'd6,
        FAIL        = 4'd7,
        BACKOFF     = 4'd8,
        FAULT       = 4'd9
    } state_t;

    // Cycles the user clock runs before the pixel domain leaves reset.
    localparam int RELEASE_HOLD_CYCLES = 16;

endpackage

// File: rtl/gth_bringup_sync.sv
// Plain flop-chain synchronizer for quasi-static status inputs.
// Each bit is synchronized independently; clears to 0 on reset.
module gth_bringup_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);
    logic [WIDTH-1:0] r_chain [STAGES];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
        end else begin
            r_chain[0] <= i_async;
            for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/gth_link_bringup_ctrl.sv
// Bring-up and recovery sequencer for the 3-lane GTH TMDS serializer: power, GT reset,
// TX done, user-clock lock, pixel release, then link watch with bounded retries.
module gth_link_bringup_ctrl
    import gth_bringup_pkg::*;
#(
    parameter int NUM_LANES          = 3,
    parameter int RESET_PULSE_CYCLES = 10,
    parameter int TIMEOUT_CYCLES     = 1250000,
    parameter int BACKOFF_CYCLES     = 12500,
    parameter int MAX_RETRIES        = 3,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                 i_s_axi_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_clear_fault,
    input  logic                 i_freerun_locked,
    input  logic                 i_usrclk_locked,
    input  logic [NUM_LANES-1:0] i_gtpowergood,
    input  logic [NUM_LANES-1:0] i_txpmaresetdone,
    input  logic                 i_tx_reset_done,
    output logic                 o_gt_reset_all,
    output logic                 o_userclk_tx_active,
    output logic                 o_pixel_resetn,
    output logic                 o_link_up,
    output logic                 o_fault,
    output logic [1:0]           o_retry_count,
    output logic [3:0]           o_state_dbg
);
    localparam int         TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRIES);

    logic [2:0]           w_ctl_s;
    logic [NUM_LANES-1:0] w_pg_s, w_pma_s;
    logic                 w_freerun_s, w_usrclk_s, w_txdone_s;
    logic                 w_pwr_ok, w_pma_ok, w_tmr_done;
    state_t               r_state, w_state_next;
    logic [TMR_W-1:0]     r_tmr, w_tmr_load;
    logic [1:0]           r_retry, w_retry_inc;
    logic                 w_gt_reset_all, w_userclk_tx_active, w_pixel_resetn, w_link_up, w_fault;
    logic                 r_gt_reset_all, r_userclk_tx_active, r_pixel_resetn, r_link_up, r_fault;

    gth_bringup_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync_ctl (
        .i_clk   (i_s_axi_clk),
        .i_rst   (i_reset),
        .i_async ({i_freerun_locked, i_usrclk_locked, i_tx_reset_done}),
        .o_sync  (w_ctl_s)
    );

    gth_bringup_sync #(.WIDTH(NUM_LANES), .STAGES(SYNC_STAGES)) u_sync_pg (
        .i_clk   (i_s_axi_clk),
        .i_rst   (i_reset),
        .i_async (i_gtpowergood),
        .o_sync  (w_pg_s)
    );

    gth_bringup_sync #(.WIDTH(NUM_LANES), .STAGES(SYNC_STAGES)) u_sync_pma (
        .i_clk   (i_s_axi_clk),
        .i_rst   (i_reset),
        .i_async (i_txpmaresetdone),
        .o_sync  (w_pma_s)
    );

    assign {w_freerun_s, w_usrclk_s, w_txdone_s} = w_ctl_s;
    assign w_pwr_ok    = &w_pg_s;
    assign w_pma_ok    = &w_pma_s;
    assign w_tmr_done  = (r_tmr == '0);
    assign w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + 2'd1;

    always_ff @(posedge i_s_axi_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Success is tested before timeout so a late success still counts.
    always_comb begin
        w_state_next = r_state;
        if (r_state != FAULT && !i_enable) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:        w_state_next = WAIT_PWR;
                WAIT_PWR:    if (w_pwr_ok && w_freerun_s)   w_state_next = ASSERT_RST;
                             else if (w_tmr_done)           w_state_next = FAIL;
                ASSERT_RST:  if (w_tmr_done)                w_state_next = WAIT_TXDONE;
                WAIT_TXDONE: if (w_txdone_s && w_pma_ok)    w_state_next = WAIT_CLK;
                             else if (w_tmr_done)           w_state_next = FAIL;
                WAIT_CLK:    if (w_usrclk_s)                w_state_next = RELEASE;
                             else if (w_tmr_done)           w_state_next = FAIL;
                RELEASE:     if (w_tmr_done)                w_state_next = UP;
                UP:          if (!(w_pwr_ok && w_usrclk_s && w_txdone_s)) w_state_next = FAIL;
                FAIL:        w_state_next = (w_retry_inc == RETRY_MAX) ? FAULT : BACKOFF;
                BACKOFF:     if (w_tmr_done)                w_state_next = WAIT_PWR;
                FAULT:       if (i_clear_fault)             w_state_next = IDLE;
                default:     w_state_next = IDLE;
            endcase
        end
    end

    // Timer holds (duration - 1) on entry, so a state lasts exactly its duration.
    always_comb begin
        w_tmr_load = '0;
        case (w_state_next)
            WAIT_PWR, WAIT_TXDONE, WAIT_CLK: w_tmr_load = TMR_W'(TIMEOUT_CYCLES - 1);
            ASSERT_RST:                      w_tmr_load = TMR_W'(RESET_PULSE_CYCLES - 1);
            RELEASE:                         w_tmr_load = TMR_W'(RELEASE_HOLD_CYCLES - 1);
            BACKOFF:                         w_tmr_load = TMR_W'(BACKOFF_CYCLES - 1);
            default:                         w_tmr_load = '0;
        endcase
    end

    always_ff @(posedge i_s_axi_clk or posedge i_reset) begin
        if (i_reset)                     r_tmr <= '0;
        else if (w_state_next != r_state) r_tmr <= w_tmr_load;
        else if (!w_tmr_done)            r_tmr <= r_tmr - TMR_W'(1);
    end

    always_ff @(posedge i_s_axi_clk or posedge i_reset) begin
        if (i_reset)
            r_retry <= '0;
        else if (r_state == FAIL)
            r_retry <= w_retry_inc;
        else if ((r_state == RELEASE && w_state_next == UP) ||
                 (r_state == FAULT && w_state_next == IDLE))
            r_retry <= '0;
    end

    // Outputs decode the upcoming state so they change on the same edge as the state.
    always_comb begin
        w_gt_reset_all      = (w_state_next == ASSERT_RST);
        w_userclk_tx_active = (w_state_next == RELEASE) || (w_state_next == UP);
        w_pixel_resetn      = (w_state_next == UP);
        w_link_up           = (w_state_next == UP);
        w_fault             = (w_state_next == FAULT);
    end

    always_ff @(posedge i_s_axi_clk or posedge i_reset) begin
        if (i_reset) begin
            r_gt_reset_all      <= 1'b0;
            r_userclk_tx_active <= 1'b0;
            r_pixel_resetn      <= 1'b0;
            r_link_up           <= 1'b0;
            r_fault             <= 1'b0;
        end else begin
            r_gt_reset_all      <= w_gt_reset_all;
            r_userclk_tx_active <= w_userclk_tx_active;
            r_pixel_resetn      <= w_pixel_resetn;
            r_link_up           <= w_link_up;
            r_fault             <= w_fault;
        end
    end

    assign o_gt_reset_all      = r_gt_reset_all;
    assign o_userclk_tx_active = r_userclk_tx_active;
    assign o_pixel_resetn      = r_pixel_resetn;
    assign o_link_up           = r_link_up;
    assign o_fault             = r_fault;
    assign o_retry_count       = r_retry;
    assign o_state_dbg         = r_state;

endmodule

// File: tb/tb_gth_link_bringup_ctrl.sv
// Bench for the GTH bring-up sequencer: directed scenarios, a per-cycle reference
// model of the sequencing rules, and literal checks on pulse widths and latencies.
module tb_gth_link_bringup_ctrl;
    localparam int NL = 3, RST_PULSE = 10, TMO = 200, BOFF = 20, MAXR = 3, SYNC = 2, HOLD = 16;
    localparam int S_IDLE = 0, S_WPWR = 1, S_ARST = 2, S_WTX = 3, S_WCLK = 4,
                   S_REL = 5, S_UP = 6, S_FAIL = 7, S_BOFF = 8, S_FLT = 9;
    localparam int SEL_STATE = 0, SEL_LINK = 1, SEL_FAULT = 2, SEL_GTRST = 3, SEL_PRN = 4;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, clear_fault = 1'b0;
    logic freerun_locked = 1'b0, usrclk_locked = 1'b0, tx_reset_done = 1'b0;
    logic [NL-1:0] gtpowergood = '0, txpmaresetdone = '0;
    logic gt_reset_all, userclk_tx_active, pixel_resetn, link_up, fault;
    logic [1:0] retry_count;
    logic [3:0] state_dbg;

    int n_cmp = 0, n_bad = 0;
    int pulses = 0, cur_w = 0, last_w = 0;

    always #5 clk = ~clk;

    gth_link_bringup_ctrl #(
        .NUM_LANES(NL), .RESET_PULSE_CYCLES(RST_PULSE), .TIMEOUT_CYCLES(TMO),
        .BACKOFF_CYCLES(BOFF), .MAX_RETRIES(MAXR), .SYNC_STAGES(SYNC)
    ) dut (
        .i_s_axi_clk(clk), .i_reset(rst), .i_enable(enable), .i_clear_fault(clear_fault),
        .i_freerun_locked(freerun_locked), .i_usrclk_locked(usrclk_locked),
        .i_gtpowergood(gtpowergood), .i_txpmaresetdone(txpmaresetdone),
        .i_tx_reset_done(tx_reset_done),
        .o_gt_reset_all(gt_reset_all), .o_userclk_tx_active(userclk_tx_active),
        .o_pixel_resetn(pixel_resetn), .o_link_up(link_up), .o_fault(fault),
        .o_retry_count(retry_count), .o_state_dbg(state_dbg)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: synchronizer delay line, state, cycles spent in it, retry count.
    logic [2*NL+2:0] hist [SYNC];
    int m_st = S_IDLE, m_cnt = 0, m_retry = 0;

    initial begin
        for (int i = 0; i < SYNC; i++) hist[i] = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_st = S_IDLE; m_cnt = 0; m_retry = 0;
                for (int i = 0; i < SYNC; i++) hist[i] = '0;
            end else begin
                logic [2*NL+2:0] s;
                logic pwr, pma, fr, uc, txd;
                int nxt, inc;
                s   = hist[SYNC-1];
                pma = &s[NL-1:0];
                pwr = &s[2*NL-1:NL];
                txd = s[2*NL];
                uc  = s[2*NL+1];
                fr  = s[2*NL+2];
                for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = {freerun_locked, usrclk_locked, tx_reset_done, gtpowergood, txpmaresetdone};
                inc = (m_retry + 1 > MAXR) ? MAXR : m_retry + 1;
                nxt = m_st;
                if (m_st != S_FLT && !enable) nxt = S_IDLE;
                else case (m_st)
                    S_IDLE: nxt = S_WPWR;
                    S_WPWR: if (pwr && fr) nxt = S_ARST; else if (m_cnt == TMO-1) nxt = S_FAIL;
                    S_ARST: if (m_cnt == RST_PULSE-1) nxt = S_WTX;
                    S_WTX:  if (txd && pma) nxt = S_WCLK; else if (m_cnt == TMO-1) nxt = S_FAIL;
                    S_WCLK: if (uc) nxt = S_REL; else if (m_cnt == TMO-1) nxt = S_FAIL;
                    S_REL:  if (m_cnt == HOLD-1) nxt = S_UP;
                    S_UP:   if (!(pwr && uc && txd)) nxt = S_FAIL;
                    S_FAIL: nxt = (inc == MAXR) ? S_FLT : S_BOFF;
                    S_BOFF: if (m_cnt == BOFF-1) nxt = S_WPWR;
                    S_FLT:  if (clear_fault) nxt = S_IDLE;
                    default: nxt = S_IDLE;
                endcase
                if (m_st == S_FAIL) m_retry = inc;
                else if ((m_st == S_REL && nxt == S_UP) || (m_st == S_FLT && nxt == S_IDLE)) m_retry = 0;
                m_cnt = (nxt != m_st) ? 0 : m_cnt + 1;
                m_st  = nxt;
            end
        end
    end

    // Every cycle: DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        chk("gt_reset_all",      int'(gt_reset_all),      int'(m_st == S_ARST));
        chk("userclk_tx_active", int'(userclk_tx_active), int'(m_st == S_REL || m_st == S_UP));
        chk("pixel_resetn",      int'(pixel_resetn),      int'(m_st == S_UP));
        chk("link_up",           int'(link_up),           int'(m_st == S_UP));
        chk("fault",             int'(fault),             int'(m_st == S_FLT));
        chk("retry_count",       int'(retry_count),       m_retry);
        chk("state_dbg",         int'(state_dbg),         m_st);
    end

    // gt_reset_all pulse counter and width recorder.
    initial forever begin
        @(negedge clk);
        if (gt_reset_all) cur_w++;
        else if (cur_w != 0) begin last_w = cur_w; pulses++; cur_w = 0; end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    function automatic int sig(input int sel);
        case (sel)
            SEL_STATE: return int'(state_dbg);
            SEL_LINK:  return int'(link_up);
            SEL_FAULT: return int'(fault);
            SEL_GTRST: return int'(gt_reset_all);
            SEL_PRN:   return int'(pixel_resetn);
            default:   return -1;
        endcase
    endfunction

    task automatic wait_until(input string what, input int sel, input int val, input int budget, output int n);
        n = 0;
        while (sig(sel) != val && n < budget) begin tick(1); n++; end
        if (sig(sel) != val) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_%s: timed out after %0d cycles, value %0d, expected %0d", what, n, sig(sel), val);
        end
    endtask

    initial begin
        int n, p0;
        tick(3);
        chk("rst_state", int'(state_dbg), S_IDLE);
        chk("rst_gt_reset_all", int'(gt_reset_all), 0);
        chk("rst_pixel_resetn", int'(pixel_resetn), 0);
        chk("rst_link_up", int'(link_up), 0);
        chk("rst_retry", int'(retry_count), 0);
        rst = 1'b0;
        tick(2);

        // Nominal bring-up
        freerun_locked = 1'b1; usrclk_locked = 1'b1; tx_reset_done = 1'b1;
        gtpowergood = '1; txpmaresetdone = '1; enable = 1'b1;
        wait_until("nom_link", SEL_LINK, 1, 100, n);
        chk("nom_latency", n, 31);
        chk("nom_rst_width", last_w, RST_PULSE);
        chk("nom_pulses", pulses, 1);
        chk("nom_pixel_resetn", int'(pixel_resetn), 1);
        chk("nom_userclk_active", int'(userclk_tx_active), 1);
        chk("nom_retry", int'(retry_count), 0);
        $display("nominal bring-up: link_up after %0d cycles, reset pulse %0d cycles", n, last_w);

        // Loss of user-clock lock while UP
        tick(5);
        usrclk_locked = 1'b0;
        wait_until("loss_prn", SEL_PRN, 0, 10, n);
        chk("loss_latency_ok", int'(n <= SYNC + 2), 1);
        chk("loss_userclk_active", int'(userclk_tx_active), 0);
        tick(1);
        chk("loss_retry", int'(retry_count), 1);
        chk("loss_state_backoff", int'(state_dbg), S_BOFF);
        usrclk_locked = 1'b1;
        wait_until("rebringup_link", SEL_LINK, 1, 200, n);
        chk("rebringup_retry", int'(retry_count), 0);
        chk("rebringup_pulses", pulses, 2);
        $display("usrclk loss: pixel_resetn low, re-bringup done after %0d cycles", n);

        // enable=0 during the GT reset pulse
        enable = 1'b0;
        tick(2);
        chk("disable_state", int'(state_dbg), S_IDLE);
        enable = 1'b1;
        wait_until("arst_start", SEL_GTRST, 1, 20, n);
        tick(3);
        enable = 1'b0;
        tick(1);
        chk("abort_gt_reset_all", int'(gt_reset_all), 0);
        chk("abort_state", int'(state_dbg), S_IDLE);
        chk("abort_retry", int'(retry_count), 0);
        $display("enable drop in ASSERT_RST: state %0d, gt_reset_all %0d", state_dbg, gt_reset_all);

        // tx_reset_done never rises -> FAULT after MAXR attempts
        tx_reset_done = 1'b0;
        tick(3);
        p0 = pulses;
        enable = 1'b1;
        wait_until("fault", SEL_FAULT, 1, 1500, n);
        chk("fault_pulses", pulses - p0, MAXR);
        chk("fault_retry", int'(retry_count), MAXR);
        chk("fault_gt_reset_all", int'(gt_reset_all), 0);
        tick(3);
        enable = 1'b0;
        tick(3);
        chk("fault_ignores_enable", int'(state_dbg), S_FLT);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        chk("clear_state", int'(state_dbg), S_IDLE);
        chk("clear_retry", int'(retry_count), 0);
        chk("clear_fault_out", int'(fault), 0);
        $display("txdone stuck: FAULT after %0d cycles, %0d reset pulses", n, pulses - p0);

        // One lane without power good -> WAIT_PWR timeout
        gtpowergood = 3'b101; tx_reset_done = 1'b1; usrclk_locked = 1'b0;
        tick(3);
        enable = 1'b1;
        wait_until("enter_wpwr", SEL_STATE, S_WPWR, 5, n);
        wait_until("pwr_fail", SEL_STATE, S_FAIL, 300, n);
        chk("pwr_timeout_cycles", n, TMO);
        tick(1);
        chk("pwr_fail_retry", int'(retry_count), 1);
        $display("lane power missing: WAIT_PWR timed out after %0d cycles", n);

        // Async reset while waiting for the user clock
        gtpowergood = '1;
        wait_until("enter_wclk", SEL_STATE, S_WCLK, 100, n);
        tick(5);
        #2 rst = 1'b1;
        #1;
        chk("areset_state", int'(state_dbg), S_IDLE);
        chk("areset_retry", int'(retry_count), 0);
        chk("areset_gt_reset_all", int'(gt_reset_all), 0);
        chk("areset_userclk_active", int'(userclk_tx_active), 0);
        chk("areset_link_up", int'(link_up), 0);
        $display("async reset in WAIT_CLK: state %0d retry %0d", state_dbg, retry_count);
        enable = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
